// File: rtl/ram_dual_port_be.sv
// Simple dual-port RAM: one write port with byte enables, one read port,
// write-first bypass, optional output register and a hardware clear engine.
module ram_dual_port_be #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int OUT_REG    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_WIDTH-1:0]   write_addr,
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   read_addr,
    output logic [DATA_WIDTH-1:0]   q,
    output logic                    q_valid,
    output logic                    init_busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int BE_W  = DATA_WIDTH / 8;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  ready;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_valid;

    assign ready     = (state == ST_READY);
    assign init_busy = (state == ST_CLEAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            unique case (state)
                ST_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) state <= ST_READY;
                end
                ST_READY: begin
                    if (clear) state <= ST_CLEAR;
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    // The array has no reset; the clear engine is its only initialiser.
    always_ff @(posedge clk) begin
        if (!ready) begin
            mem[cnt] <= '0;
        end else if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) mem[write_addr][8*i +: 8] <= data[8*i +: 8];
            end
        end
    end

    // Write-first per byte when both ports hit the same word.
    always_comb begin
        rd_word = mem[read_addr];
        for (int i = 0; i < BE_W; i++) begin
            if (we && be[i] && (write_addr == read_addr)) begin
                rd_word[8*i +: 8] = data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= ready && re;
            if (ready && re) s1_data <= rd_word;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] s2_data;
            logic                  s2_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_data  <= '0;
                    s2_valid <= 1'b0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) s2_data <= s1_data;
                end
            end

            assign q       = s2_data;
            assign q_valid = s2_valid;
        end else begin : g_noreg
            assign q       = s1_data;
            assign q_valid = s1_valid;
        end
    endgenerate

endmodule

// File: doc/ram_dual_port_be.md
# ram_dual_port_be

Parametrised simple dual-port RAM with one write port and one read port, per-byte write enables, write-to-read bypass, an optional output pipeline register and a hardware clear engine. The clear engine zeroes every location after reset and on request. It is the general-purpose buffer memory for the team's datapath blocks and replaces fixed 64×8 instances.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8
- ADDR_WIDTH, 6, address width; DEPTH = 2**ADDR_WIDTH words
- OUT_REG, 0, 0 = one-cycle read latency, 1 = extra output register (two-cycle latency)
- clk  in  1  rising-edge clock for all logic
- rst_n  in  1  asynchronous reset, active low
- clear  in  1  single-cycle pulse; requests zeroing of the whole array (honoured only in READY)
- we  in  1  write enable
- be  in  DATA_WIDTH/8  byte enables; bit i covers data[8i+7:8i]
- write_addr  in  ADDR_WIDTH  write address
- data  in  DATA_WIDTH  write data
- re  in  1  read enable
- read_addr  in  ADDR_WIDTH  read address
- q  out  DATA_WIDTH  read data
- q_valid  out  1  q holds data for an accepted read, valid for one cycle
- init_busy  out  1  clear engine active; user reads and writes are ignored

## Operation
- Clear engine has two states, CLEAR and READY.
- Reset puts the engine in CLEAR with clear counter = 0.
- CLEAR: each cycle writes 0 to ram[counter] and increments the counter. In the cycle the counter = DEPTH-1, the engine writes that last location and moves to READY. The counter wraps to 0.
- READY: clear=1 moves the engine to CLEAR on the next edge. The user we/re in that same cycle still execute.
- Reset while in CLEAR or READY aborts immediately. Clearing restarts from address 0 after rst_n rises.
- The array itself has no reset; its contents become defined only through the clear engine.
- Write (READY only): for each i with we=1 and be[i]=1, ram[write_addr] byte i <= data byte i. Bytes with be[i]=0 are unchanged. we=1 with be=0 is a no-op.
- Read (READY only): re=1 captures the read word into stage 1.
- Bypass: if re=1, we=1 and read_addr==write_addr in the same cycle, each byte with be[i]=1 returns the new data byte. Bytes with be[i]=0 return the stored byte (write-first per byte).
- re=0, or any cycle in CLEAR: stage 1 holds its previous value and stage-1 valid = 0.
- OUT_REG=1: stage 2 copies stage 1 data whenever stage-1 valid=1, otherwise it holds. q_valid is stage-1 valid delayed one cycle.
- q is never forced to 0 except by reset. It holds the last read result between reads.

## Timing
- Reset values: q = 0, q_valid = 0, init_busy = 1. Internal stage-2 data and valid are also 0.
- init_busy = 1 exactly while the engine is in CLEAR.
- After rst_n rises, init_busy stays 1 for DEPTH cycles (64 for defaults), then drops to 0.
- A clear pulse accepted at edge N sets init_busy=1 after edge N. init_busy falls DEPTH cycles later.
- Read latency: re at edge N gives q/q_valid after edge N when OUT_REG=0, and after edge N+1 when OUT_REG=1.
- Reads are fully pipelined, one per cycle. Back-to-back reads produce back-to-back q_valid pulses.
- Write latency: a write at edge N is visible to a non-bypassed read at edge N+1 or later.
- A read issued in the last READY cycle before clear takes effect completes normally, including its OUT_REG stage.
- A read of any location issued right after init_busy falls returns 0 unless that location has been rewritten.

## Test plan
- Reset then idle (DEPTH=16, OUT_REG=0): init_busy high for 16 cycles after rst_n rises. Read addr 0..15 -> q=0x00000000 with q_valid=1, one cycle after each re.
- Byte-enable write: write 0xAABBCCDD, be=1111 to addr 3, then 0x11223344, be=0101 to addr 3; read addr 3 -> q=0xAA22CC44.
- Bypass: addr 5 holds 0x01020304; same cycle issue we=1, be=0011, data=0xFFFFEEEE to addr 5 and re=1 at addr 5 -> q=0x0102EEEE. A following read -> 0x0102EEEE.
- OUT_REG=1 pipeline: reads of addr 1,2,3 on consecutive cycles (holding 0x10,0x20,0x30) -> q=0x10,0x20,0x30 on consecutive cycles. The first appears two cycles after the first re; q_valid is high for exactly 3 cycles.
- Clear request: fill all locations with 0xFFFFFFFF and pulse clear. During init_busy, writes and reads are ignored (q_valid=0, q holds). Afterwards every address reads 0.
- Reset mid-clear: assert rst_n=0 at clear counter 7 -> q=0, q_valid=0, init_busy=1 immediately. After release, the full DEPTH-cycle clear runs again from address 0.
